// File: rtl/serial_subtractor_pkg.sv
// Shared types and elaboration checks for the bit-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The slice must tile the word exactly, otherwise the last cycle would straddle the MSB.
  function automatic bit width_ok(input int width, input int bpc);
    return (width >= 1) && (bpc >= 1) && ((width % bpc) == 0);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor built from two half subtractors and an OR of their borrows.
module full_subtractor (
  input  logic minuend,
  input  logic subtrahend,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  logic d1;
  logic b1;
  logic b2;

  half_subtractor u_hs_ab (
    .minuend    (minuend),
    .subtrahend (subtrahend),
    .diff       (d1),
    .borrow_out (b1)
  );

  half_subtractor u_hs_bin (
    .minuend    (d1),
    .subtrahend (borrow_in),
    .diff       (diff),
    .borrow_out (b2)
  );

  assign borrow_out = b1 | b2;

endmodule

// File: rtl/half_subtractor.sv
// Single-bit half subtractor: diff = minuend ^ subtrahend, borrow when 0 - 1.
module half_subtractor (
  input  logic minuend,
  input  logic subtrahend,
  output logic diff,
  output logic borrow_out
);

  assign diff       = minuend ^ subtrahend;
  assign borrow_out = ~minuend & subtrahend;

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = minuend - subtrahend - borrow_in, BITS_PER_CYCLE bits per clock.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1; ready never depends on valid.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output state_t           state_dbg
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if (!width_ok(WIDTH, BITS_PER_CYCLE)) begin : g_bad_params
    $error("serial_subtractor: BITS_PER_CYCLE must divide WIDTH");
  end

  state_t                      state;
  logic [WIDTH-1:0]            a_q;
  logic [WIDTH-1:0]            b_q;
  logic [WIDTH-1:0]            res_q;
  logic                        borrow_q;
  logic                        a_msb_q;
  logic                        b_msb_q;
  logic [CNT_W-1:0]            cnt_q;

  logic [BITS_PER_CYCLE:0]     chain;
  logic [BITS_PER_CYCLE-1:0]   slice_d;
  logic [WIDTH-1:0]            res_next;

  assign chain[0] = borrow_q;

  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_slice
    full_subtractor u_fs (
      .minuend    (a_q[gi]),
      .subtrahend (b_q[gi]),
      .borrow_in  (chain[gi]),
      .diff       (slice_d[gi]),
      .borrow_out (chain[gi+1])
    );
  end

  // New slice lands at the top; earlier slices drift toward bit 0 as cycles pass.
  assign res_next = (res_q >> BITS_PER_CYCLE) | (WIDTH'(slice_d) << (WIDTH - BITS_PER_CYCLE));

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      borrow_q   <= 1'b0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= minuend;
            b_q      <= subtrahend;
            borrow_q <= borrow_in;
            a_msb_q  <= minuend[WIDTH-1];
            b_msb_q  <= subtrahend[WIDTH-1];
            res_q    <= '0;
            cnt_q    <= '0;
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          a_q      <= a_q >> BITS_PER_CYCLE;
          b_q      <= b_q >> BITS_PER_CYCLE;
          res_q    <= res_next;
          borrow_q <= chain[BITS_PER_CYCLE];
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(N - 1)) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            diff       <= res_next;
            borrow_out <= chain[BITS_PER_CYCLE];
            overflow   <= (a_msb_q != b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH/BPC = 8/1, 8/4 and 4/2.
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 0: WIDTH=8 BPC=1
  logic       iv0, ir0, bi0, ov0, or0, bo0, of0;
  logic [7:0] m0, s0, df0;
  state_t     st0;
  // DUT 1: WIDTH=8 BPC=4
  logic       iv1, ir1, bi1, ov1, or1, bo1, of1;
  logic [7:0] m1, s1, df1;
  state_t     st1;
  // DUT 2: WIDTH=4 BPC=2
  logic       iv2, ir2, bi2, ov2, or2, bo2, of2;
  logic [3:0] m2, s2, df2;
  state_t     st2;

  serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .minuend(m0), .subtrahend(s0),
    .borrow_in(bi0), .out_valid(ov0), .out_ready(or0), .diff(df0), .borrow_out(bo0),
    .overflow(of0), .state_dbg(st0));

  serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .minuend(m1), .subtrahend(s1),
    .borrow_in(bi1), .out_valid(ov1), .out_ready(or1), .diff(df1), .borrow_out(bo1),
    .overflow(of1), .state_dbg(st1));

  serial_subtractor #(.WIDTH(4), .BITS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .minuend(m2), .subtrahend(s2),
    .borrow_in(bi2), .out_valid(ov2), .out_ready(or2), .diff(df2), .borrow_out(bo2),
    .overflow(of2), .state_dbg(st2));

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!rst && $isunknown({iv0, iv1, iv2})) begin
      failures++;
      $display("FAIL in_valid_x actual=%b%b%b expected=known", iv0, iv1, iv2);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver helpers ----------------
  task automatic drive_in(input int id, input logic v, input logic [7:0] a, input logic [7:0] b,
                          input logic bin);
    case (id)
      0: begin iv0 = v; m0 = a; s0 = b; bi0 = bin; end
      1: begin iv1 = v; m1 = a; s1 = b; bi1 = bin; end
      default: begin iv2 = v; m2 = a[3:0]; s2 = b[3:0]; bi2 = bin; end
    endcase
  endtask

  task automatic drive_or(input int id, input logic v);
    case (id)
      0: or0 = v;
      1: or1 = v;
      default: or2 = v;
    endcase
  endtask

  function automatic logic get_ov(input int id);
    case (id)
      0: return ov0;
      1: return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic logic get_ir(input int id);
    case (id)
      0: return ir0;
      1: return ir1;
      default: return ir2;
    endcase
  endfunction

  function automatic logic [9:0] get_res(input int id);
    case (id)
      0: return {bo0, of0, df0};
      1: return {bo1, of1, df1};
      default: return {bo2, of2, 4'h0, df2};
    endcase
  endfunction

  // Accept one operation, count edges until out_valid, then consume the result.
  task automatic run_op(input int id, input logic [7:0] a, input logic [7:0] b, input logic bin,
                        output logic [7:0] d, output logic bo, output logic of, output int lat);
    logic [9:0] r;
    @(negedge clk);
    drive_in(id, 1'b1, a, b, bin);
    @(posedge clk);
    #1;
    drive_in(id, 1'b0, a, b, bin);
    lat = 0;
    while (!get_ov(id) && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r  = get_res(id);
    bo = r[9];
    of = r[8];
    d  = r[7:0];
    @(negedge clk);
    drive_or(id, 1'b1);
    @(posedge clk);
    #1;
    drive_or(id, 1'b0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
    logic       of;
    int         lat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [7:0] d;
    logic       bo, of;
    int         lat;
    logic [4:0] full;
    logic [3:0] a4, b4, ed;
    logic       eof;

    vecs[0] = '{0, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 8};
    vecs[1] = '{0, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 8};
    vecs[2] = '{0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 8};
    vecs[3] = '{0, 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 8};
    vecs[4] = '{0, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 8};
    vecs[5] = '{0, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 8};
    vecs[6] = '{1, 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1, 2};
    vecs[7] = '{1, 8'h3C, 8'hC3, 1'b0, 8'h79, 1'b1, 1'b0, 2};
    vecs[8] = '{2, 8'h03, 8'h05, 1'b0, 8'h0E, 1'b1, 1'b0, 2};

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_in(i, 1'b0, 8'h00, 8'h00, 1'b0);
      drive_or(i, 1'b0);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst%0d_in_ready", i), 32'(get_ir(i)), 32'd1);
      check($sformatf("rst%0d_out_valid", i), 32'(get_ov(i)), 32'd0);
      check($sformatf("rst%0d_result", i), 32'(get_res(i)), 32'd0);
    end
    check("rst_state0", 32'(st0), 32'(IDLE));
    check("rst_state1", 32'(st1), 32'(IDLE));
    check("rst_state2", 32'(st2), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      check($sformatf("vec%0d_in_ready", i), 32'(get_ir(vecs[i].id)), 32'd1);
      run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].bin, d, bo, of, lat);
      check($sformatf("vec%0d_diff", i), 32'(d), 32'(vecs[i].d));
      check($sformatf("vec%0d_borrow_out", i), 32'(bo), 32'(vecs[i].bo));
      check($sformatf("vec%0d_overflow", i), 32'(of), 32'(vecs[i].of));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Back-pressure: 0x33 - 0x11 held in DONE for 5 cycles while a new request knocks.
    @(negedge clk);
    drive_in(0, 1'b1, 8'h33, 8'h11, 1'b0);
    @(posedge clk);
    #1;
    drive_in(0, 1'b0, 8'h33, 8'h11, 1'b0);
    lat = 0;
    while (!ov0 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("bp_latency", 32'(lat), 32'd8);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive_in(0, 1'b1, 8'hFF, 8'h01, 1'b1);
      @(posedge clk);
      #1;
      check($sformatf("bp%0d_out_valid", k), 32'(ov0), 32'd1);
      check($sformatf("bp%0d_diff", k), 32'(df0), 32'h22);
      check($sformatf("bp%0d_in_ready", k), 32'(ir0), 32'd0);
      check($sformatf("bp%0d_state", k), 32'(st0), 32'(DONE));
    end
    @(negedge clk);
    drive_in(0, 1'b0, 8'h00, 8'h00, 1'b0);
    or0 = 1'b1;
    @(posedge clk);
    #1;
    or0 = 1'b0;
    check("bp_release_state", 32'(st0), 32'(IDLE));
    check("bp_release_in_ready", 32'(ir0), 32'd1);
    check("bp_release_out_valid", 32'(ov0), 32'd0);
    check("bp_release_diff_held", 32'(df0), 32'h22);

    // Reset in the middle of a SHIFT sequence discards the operation.
    @(negedge clk);
    drive_in(0, 1'b1, 8'hAA, 8'h11, 1'b0);
    @(posedge clk);
    #1;
    drive_in(0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_state_shift", 32'(st0), 32'(SHIFT));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_state", 32'(st0), 32'(IDLE));
    check("mid_rst_in_ready", 32'(ir0), 32'd1);
    check("mid_rst_out_valid", 32'(ov0), 32'd0);
    check("mid_rst_result", 32'(get_res(0)), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(0, 8'h09, 8'h04, 1'b0, d, bo, of, lat);
    check("post_rst_diff", 32'(d), 32'h05);
    check("post_rst_borrow_out", 32'(bo), 32'd0);
    check("post_rst_latency", 32'(lat), 32'd8);

    // Exhaustive sweep of the 4-bit instance against an arithmetic reference.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int bin = 0; bin < 2; bin++) begin
          a4   = 4'(a);
          b4   = 4'(b);
          full = {1'b0, a4} - {1'b0, b4} - 5'(bin);
          ed   = full[3:0];
          eof  = (a4[3] != b4[3]) && (ed[3] != a4[3]);
          run_op(2, {4'h0, a4}, {4'h0, b4}, 1'(bin), d, bo, of, lat);
          check($sformatf("sw_%0h_%0h_%0d_diff", a, b, bin), 32'(d), 32'(ed));
          check($sformatf("sw_%0h_%0h_%0d_borrow", a, b, bin), 32'(bo), 32'(full[4]));
          check($sformatf("sw_%0h_%0h_%0d_ovf", a, b, bin), 32'(of), 32'(eof));
          check($sformatf("sw_%0h_%0h_%0d_lat", a, b, bin), 32'(lat), 32'd2);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
